// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 32-bit ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_OPCODE_CHECK_EN: opcodes 3'b101..3'b111 bypass the ALU and return an error directly.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*3-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_result,
  output logic                   resp_error,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_opcode,
  input  logic [31:0]            alu_result,
  input  logic                   alu_error,
  output logic                   busy,
  output logic [CNT_W-1:0]       err_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [IDX_W-1:0]    r_last_gnt;
  logic [NUM_REQ-1:0]  r_gnt_oh;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [31:0]         r_resp_result;
  logic                r_resp_error;
  logic [31:0]         r_alu_a;
  logic [31:0]         r_alu_b;
  logic [2:0]          r_alu_opcode;
  logic                r_busy;
  logic [CNT_W-1:0]    r_err_count;

  logic [IDX_W-1:0]    w_scan;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_gnt_found;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic [2:0]          w_sel_op;
  logic                w_bypass;
  logic                w_xfer;

  // Rotating search starting just after the last grant; the first valid index wins.
  always_comb begin
    w_scan      = '0;
    w_gnt_idx   = '0;
    w_gnt_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan = IDX_W'((32'(r_last_gnt) + k) % NUM_REQ);
      if (!w_gnt_found && req_valid[w_scan]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan;
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_found && (w_gnt_idx == IDX_W'(i))) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_a     = req_a[32*i +: 32];
        w_sel_b     = req_b[32*i +: 32];
        w_sel_op    = req_opcode[3*i +: 3];
      end
    end
  end

`ifdef ALU_ARB_OPCODE_CHECK_EN
  assign w_bypass = (w_sel_op >= 3'b101);
`else
  assign w_bypass = 1'b0;
`endif

  // r_resp_valid is one-hot on the granted requester only while in RESP.
  assign w_xfer = (r_state == S_RESP) && (|(resp_ready & r_resp_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = w_gnt_oh;
        if (w_gnt_found) begin
          w_state_next = w_bypass ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_RESP;
      S_RESP: begin
        if (w_xfer) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt    <= IDX_W'(NUM_REQ - 1);
      r_gnt_oh      <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_resp_error  <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_opcode  <= '0;
      r_busy        <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_gnt_oh   <= w_gnt_oh;
            r_last_gnt <= w_gnt_idx;
            if (w_bypass) begin
              r_resp_result <= '0;
              r_resp_error  <= 1'b1;
              r_resp_valid  <= w_gnt_oh;
            end else begin
              r_alu_a      <= w_sel_a;
              r_alu_b      <= w_sel_b;
              r_alu_opcode <= w_sel_op;
            end
          end
        end
        S_ISSUE: begin
        end
        S_WAIT: begin
          r_resp_result <= alu_result;
          r_resp_error  <= alu_error;
          r_resp_valid  <= r_gnt_oh;
        end
        S_RESP: begin
          if (w_xfer) begin
            r_resp_valid <= '0;
            if (r_resp_error && (r_err_count != '1)) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_error  = r_resp_error;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_opcode;
  assign busy        = r_busy;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a = '0;
  logic [N*32-1:0]   req_b = '0;
  logic [N*3-1:0]    req_opcode = '0;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready = '0;
  logic [31:0]       resp_result;
  logic              resp_error;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_opcode;
  logic [31:0]       alu_result;
  logic              alu_error;
  logic              busy;
  logic [CW-1:0]     err_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_ptr = N - 1;
  int m_err = 0;

  alu_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_error(resp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU semantics: 0 ADD, 1 SUB (signed overflow flags error), 2 AND, 3 OR, 4 XOR, others undefined.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0: begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // External registered ALU sharing the arbiter's reset.
  always @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      alu_error  <= 1'b0;
    end else begin
      {alu_error, alu_result} <= alu_fn(alu_a, alu_b, alu_opcode);
    end
  end

  function automatic int exp_gnt(input int ptr, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef ALU_ARB_OPCODE_CHECK_EN
    return (op >= 3'd5) ? 1 : 3;
`else
    return (op == op) ? 3 : 3;
`endif
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Drives one request set, observes grant, response and hold behaviour; performs no comparisons.
  task automatic do_txn(input logic [N-1:0] mask, input logic [N-1:0] bp_mask,
                        input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                        input logic [N*3-1:0] op, input int delay,
                        output logic [N-1:0] o_gnt, output logic [N-1:0] o_rv,
                        output int o_lat, output int o_acc,
                        output logic [31:0] o_res, output logic o_err,
                        output logic o_hold_ok, output logic o_timeout);
    int n;
    o_gnt = '0; o_rv = '0; o_lat = 0; o_acc = 0; o_res = '0; o_err = 1'b0;
    o_hold_ok = 1'b1; o_timeout = 1'b0;
    req_valid = mask; req_a = a; req_b = b; req_opcode = op; resp_ready = '0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 16) begin
      @(posedge clk); @(negedge clk); #1; n++;
    end
    if (req_ready == '0) begin
      o_timeout = 1'b1; req_valid = '0; return;
    end
    o_gnt = req_ready;
    o_acc = cyc;
    @(posedge clk); @(negedge clk);
    req_valid = bp_mask & ~o_gnt;
    #1;
    o_lat = 1;
    while (resp_valid == '0 && o_lat < 16) begin
      @(posedge clk); @(negedge clk); #1; o_lat++;
    end
    if (resp_valid == '0) begin
      o_timeout = 1'b1; req_valid = '0; return;
    end
    o_rv = resp_valid; o_res = resp_result; o_err = resp_error;
    for (int d = 0; d < delay; d++) begin
      resp_ready = ~o_gnt;
      @(posedge clk); @(negedge clk); #1;
      if (resp_valid !== o_rv || resp_result !== o_res || resp_error !== o_err || req_ready !== '0)
        o_hold_ok = 1'b0;
    end
    resp_ready = o_gnt;
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    resp_ready = '0;
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0; resp_ready = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    m_ptr = N - 1;
    m_err = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, resp_valid, resp_result, resp_error, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rr=%b rv=%b res=%h err=%b busy=%b, required all zero",
               req_ready, resp_valid, resp_result, resp_error, busy);
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode} !== '0) begin
      errors++;
      $display("FAIL reset_alu_inputs: a=%h b=%h op=%b, required zero", alu_a, alu_b, alu_opcode);
    end
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL reset_err_count: got %0d required 0", err_count);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g, rv; int lat, acc; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    a = '0; b = '0; op = '0;
    a[31:0] = 32'h0000_0005; b[31:0] = 32'h0000_0003; op[2:0] = 3'd0;
    do_txn(4'b0001, 4'b0000, a, b, op, 0, g, rv, lat, acc, res, e, hold, to);
    m_ptr = 0;
    checks++;
    if (to !== 1'b0 || g !== 4'b0001 || rv !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: timeout=%b gnt=%b rv=%b, required 0 0001 0001", to, g, rv);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL single_latency: got %0d required 3", lat);
    end
    checks++;
    if (res !== 32'h8 || e !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got %h/%b required 00000008/0", res, e);
    end
    checks++;
    if (err_count !== CW'(0) || busy !== 1'b0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL single_after: err_count=%0d busy=%b rv=%b, required 0 0 0", err_count, busy, resp_valid);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] g, rv; int lat, acc; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    a = '0; b = '0; op = '0;
    a[2*32 +: 32] = 32'h7FFF_FFFF; b[2*32 +: 32] = 32'h1; op[2*3 +: 3] = 3'd0;
    do_txn(4'b0100, 4'b0000, a, b, op, 1, g, rv, lat, acc, res, e, hold, to);
    m_ptr = 2;
    m_err = sat_inc(m_err);
    checks++;
    if (to !== 1'b0 || g !== 4'b0100 || rv !== 4'b0100) begin
      errors++;
      $display("FAIL overflow_grant: timeout=%b gnt=%b rv=%b, required 0 0100 0100", to, g, rv);
    end
    checks++;
    if (res !== 32'h8000_0000 || e !== 1'b1) begin
      errors++;
      $display("FAIL overflow_result: got %h/%b required 80000000/1", res, e);
    end
    checks++;
    if (err_count !== CW'(m_err)) begin
      errors++;
      $display("FAIL overflow_err_count: got %0d required %0d", err_count, m_err);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, rv; int lat, acc, prev, eg; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      a[32*i +: 32] = $urandom;
      b[32*i +: 32] = $urandom;
      op[3*i +: 3]  = 3'd4;
    end
    prev = 0;
    for (int t = 0; t < 5; t++) begin
      eg = exp_gnt(m_ptr, 4'b1111);
      do_txn(4'b1111, 4'b1111, a, b, op, 0, g, rv, lat, acc, res, e, hold, to);
      checks++;
      if (to !== 1'b0 || g !== onehot(order[t]) || g !== onehot(eg) || rv !== onehot(eg)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: timeout=%b gnt=%b rv=%b, required %b", t, to, g, rv, onehot(order[t]));
      end
      checks++;
      if (res !== (a[32*eg +: 32] ^ b[32*eg +: 32]) || e !== 1'b0 || lat != 3) begin
        errors++;
        $display("FAIL rr_result[%0d]: got %h/%b lat %0d required %h/0 lat 3", t, res, e, lat,
                 a[32*eg +: 32] ^ b[32*eg +: 32]);
      end
      if (t > 0) begin
        checks++;
        if (acc - prev != 4) begin
          errors++;
          $display("FAIL rr_throughput[%0d]: accept interval %0d required 4", t, acc - prev);
        end
      end
      prev = acc;
      m_ptr = eg;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g, rv; int lat, acc; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    a = '0; b = '0; op = '0;
    a[1*32 +: 32] = 32'hF0F0_F0F0; b[1*32 +: 32] = 32'hFF00_FF00; op[1*3 +: 3] = 3'd2;
    do_txn(4'b0010, 4'b1111, a, b, op, 5, g, rv, lat, acc, res, e, hold, to);
    m_ptr = 1;
    checks++;
    if (to !== 1'b0 || rv !== 4'b0010 || res !== 32'hF000_F000 || e !== 1'b0) begin
      errors++;
      $display("FAIL bp_response: timeout=%b rv=%b res=%h err=%b, required 0 0010 f000f000 0", to, rv, res, e);
    end
    checks++;
    if (hold !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: stable=%b required 1", hold);
    end
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL bp_after: busy=%b rv=%b required 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_undef_opcode();
    logic [N-1:0] g, rv; int lat, acc; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    logic [66:0] alu_before;
    a = '0; b = '0; op = '0;
    a[3*32 +: 32] = 32'h1234_5678; b[3*32 +: 32] = 32'h0BAD_F00D; op[3*3 +: 3] = 3'b110;
    alu_before = {alu_a, alu_b, alu_opcode};
    do_txn(4'b1000, 4'b0000, a, b, op, 0, g, rv, lat, acc, res, e, hold, to);
    m_ptr = 3;
    m_err = sat_inc(m_err);
    checks++;
    if (to !== 1'b0 || rv !== 4'b1000 || res !== 32'h0 || e !== 1'b1) begin
      errors++;
      $display("FAIL undef_result: timeout=%b rv=%b res=%h err=%b, required 0 1000 0 1", to, rv, res, e);
    end
    checks++;
    if (lat != exp_lat(3'b110)) begin
      errors++;
      $display("FAIL undef_latency: got %0d required %0d", lat, exp_lat(3'b110));
    end
`ifdef ALU_ARB_OPCODE_CHECK_EN
    checks++;
    if ({alu_a, alu_b, alu_opcode} !== alu_before) begin
      errors++;
      $display("FAIL undef_alu_untouched: got %h required %h", {alu_a, alu_b, alu_opcode}, alu_before);
    end
`endif
    checks++;
    if (err_count !== CW'(m_err)) begin
      errors++;
      $display("FAIL undef_err_count: got %0d required %0d", err_count, m_err);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] g, rv; int lat, acc; logic [31:0] res; logic e, hold, to, stray;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op;
    a = '0; b = '0; op = '0;
    a[31:0] = 32'd1; b[31:0] = 32'd2;
    req_valid = 4'b0001; req_a = a; req_b = b; req_opcode = op;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rw_accept: rr=%b required 0001", req_ready);
    end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    m_ptr = N - 1;
    m_err = 0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL rw_after_reset: busy=%b rv=%b required 0 0", busy, resp_valid);
    end
    stray = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk); #1;
      if (resp_valid !== '0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0 || err_count !== '0) begin
      errors++;
      $display("FAIL rw_no_response: stray=%b err_count=%0d required 0 0", stray, err_count);
    end
    a[32 +: 32] = 32'd7; b[32 +: 32] = 32'd9;
    do_txn(4'b0011, 4'b0000, a, b, op, 0, g, rv, lat, acc, res, e, hold, to);
    checks++;
    if (to !== 1'b0 || g !== 4'b0001 || res !== 32'd3) begin
      errors++;
      $display("FAIL rw_next_grant: timeout=%b gnt=%b res=%h required 0 0001 00000003", to, g, res);
    end
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] g, rv, mask, bp; int lat, acc, eg, dly; logic [31:0] res; logic e, hold, to;
    logic [N*32-1:0] a, b; logic [N*3-1:0] op; logic [32:0] ex;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom);
      if (mask == '0) mask = N'(1 << $urandom_range(0, N - 1));
      bp = N'($urandom);
      dly = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        a[32*i +: 32] = $urandom;
        b[32*i +: 32] = $urandom;
        op[3*i +: 3]  = 3'($urandom_range(0, 7));
      end
      eg = exp_gnt(m_ptr, mask);
      ex = alu_fn(a[32*eg +: 32], b[32*eg +: 32], op[3*eg +: 3]);
      do_txn(mask, bp, a, b, op, dly, g, rv, lat, acc, res, e, hold, to);
      m_ptr = eg;
      if (ex[32]) m_err = sat_inc(m_err);
      checks++;
      if (to !== 1'b0 || g !== onehot(eg) || rv !== onehot(eg)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: timeout=%b gnt=%b rv=%b required %b", t, to, g, rv, onehot(eg));
      end
      checks++;
      if (res !== ex[31:0] || e !== ex[32] || lat != exp_lat(op[3*eg +: 3])) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h/%b lat %0d required %h/%b lat %0d", t, res, e, lat,
                 ex[31:0], ex[32], exp_lat(op[3*eg +: 3]));
      end
      checks++;
      if (hold !== 1'b1 || err_count !== CW'(m_err)) begin
        errors++;
        $display("FAIL rand_hold_count[%0d]: stable=%b err_count=%0d required 1 %0d", t, hold, err_count, m_err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_undef_opcode();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
